// File: rtl/array_rf_ctrl.sv
// Refresh controller: times refresh obligations, raises rf_req, and on grant walks
// RF_ROWS rows with activate/precharge cycles using a wrapping row pointer.
module array_rf_ctrl #(
  parameter int AXI_RADDR_WIDTH = 14,
  parameter int RF_PERIOD       = 2000,
  parameter int RF_ROWS         = 8,
  parameter int TRAS            = 4,
  parameter int TRP             = 3,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rf_en,
  input  logic                       rf_start,
  output logic                       rf_req,
  output logic                       rf_busy,
  output logic                       rf_done,
  output logic                       array_banksel_n_rf,
  output logic [AXI_RADDR_WIDTH-1:0] array_raddr_rf
);

  // state | meaning
  // IDLE  | waiting for rf_start grant
  // ACT   | row activated, banksel_n low for TRAS cycles
  // PRE   | precharge, banksel_n high for TRP cycles, then advance row
  // DONE  | burst complete, one-cycle rf_done, retire one pending obligation
  typedef enum logic [1:0] {IDLE, ACT, PRE, DONE} state_t;

  localparam int RW = $clog2(RF_ROWS + 1);

  state_t                     state, state_nxt;
  logic [CNT_WIDTH-1:0]       int_cnt;
  logic [CNT_WIDTH-1:0]       tcnt, tcnt_nxt;
  logic [RW-1:0]              row_cnt, row_cnt_nxt;
  logic [AXI_RADDR_WIDTH-1:0] row_ptr, row_ptr_nxt;
  logic [2:0]                 pending;
  logic                       expiry;
  logic                       dec;

  assign expiry = rf_en && (int_cnt == CNT_WIDTH'(RF_PERIOD - 1));
  assign dec    = (state == DONE) && (pending != 3'd0);

  always_comb begin
    state_nxt   = state;
    tcnt_nxt    = tcnt + CNT_WIDTH'(1);
    row_cnt_nxt = row_cnt;
    row_ptr_nxt = row_ptr;
    case (state)
      IDLE: begin
        tcnt_nxt = '0;
        if (rf_start) begin
          state_nxt   = ACT;
          row_cnt_nxt = '0;
        end
      end
      ACT: begin
        if (tcnt == CNT_WIDTH'(TRAS - 1)) begin
          state_nxt = PRE;
          tcnt_nxt  = '0;
        end
      end
      PRE: begin
        if (tcnt == CNT_WIDTH'(TRP - 1)) begin
          tcnt_nxt    = '0;
          row_ptr_nxt = row_ptr + AXI_RADDR_WIDTH'(1);
          row_cnt_nxt = row_cnt + RW'(1);
          state_nxt   = (row_cnt == RW'(RF_ROWS - 1)) ? DONE : ACT;
        end
      end
      DONE: begin
        tcnt_nxt  = '0;
        state_nxt = IDLE;
      end
      default: begin
        tcnt_nxt  = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tcnt    <= '0;
      row_cnt <= '0;
      row_ptr <= '0;
    end else begin
      state   <= state_nxt;
      tcnt    <= tcnt_nxt;
      row_cnt <= row_cnt_nxt;
      row_ptr <= row_ptr_nxt;
    end
  end

  // Interval timer runs independently of the burst FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_cnt <= '0;
    end else if (!rf_en || expiry) begin
      int_cnt <= '0;
    end else begin
      int_cnt <= int_cnt + CNT_WIDTH'(1);
    end
  end

  // Simultaneous expiry and retire cancel out; expiry saturates at 7.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 3'd0;
    end else if (expiry && !dec) begin
      if (pending != 3'd7) pending <= pending + 3'd1;
    end else if (dec && !expiry) begin
      pending <= pending - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_req             <= 1'b0;
      rf_busy            <= 1'b0;
      rf_done            <= 1'b0;
      array_banksel_n_rf <= 1'b1;
      array_raddr_rf     <= '0;
    end else begin
      rf_req             <= (pending != 3'd0);
      rf_busy            <= (state != IDLE);
      rf_done            <= (state == DONE);
      array_banksel_n_rf <= (state != ACT);
      array_raddr_rf     <= row_ptr;
    end
  end

endmodule

// File: tb/tb_array_rf_ctrl.sv
// Randomized and directed bench for array_rf_ctrl against a burst-offset reference model.
module tb_array_rf_ctrl;

  localparam int AW = 4;
  localparam int PERIOD = 20;
  localparam int ROWS = 2;
  localparam int TRAS = 4;
  localparam int TRP = 3;
  localparam int T = TRAS + TRP;
  localparam int L = ROWS * T;

  logic          clk, rst_n, rf_en, rf_start;
  logic          rf_req, rf_busy, rf_done, banksel_n;
  logic [AW-1:0] raddr;

  int n_chk, n_fail;
  int m_cnt, m_pend, m_bk, m_ptr, m_raddr, m_req;

  array_rf_ctrl #(
    .AXI_RADDR_WIDTH(AW), .RF_PERIOD(PERIOD), .RF_ROWS(ROWS),
    .TRAS(TRAS), .TRP(TRP), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rf_en(rf_en), .rf_start(rf_start),
    .rf_req(rf_req), .rf_busy(rf_busy), .rf_done(rf_done),
    .array_banksel_n_rf(banksel_n), .array_raddr_rf(raddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_pend = 0; m_bk = -1; m_ptr = 0; m_raddr = 0; m_req = 0;
  endtask

  // m_bk = clock edges since the accepted grant; -1 when no burst is in flight.
  task automatic model_edge();
    int pk, inc, dc, np;
    pk = m_bk;
    inc = (rf_en && m_cnt == PERIOD - 1) ? 1 : 0;
    dc = (pk == L && m_pend > 0) ? 1 : 0;
    m_req = (m_pend != 0) ? 1 : 0;
    np = m_pend + inc - dc;
    m_pend = (np > 7) ? 7 : np;
    m_cnt = rf_en ? ((m_cnt + 1) % PERIOD) : 0;
    m_raddr = m_ptr;
    if (rf_start && (pk < 0 || pk == L + 1)) m_bk = 0;
    else if (pk >= 0) m_bk = (pk + 1 > L + 1) ? -1 : pk + 1;
    if (m_bk >= 1 && m_bk <= L && (m_bk % T) == 0) m_ptr = (m_ptr + 1) % (1 << AW);
  endtask

  task automatic compare_all();
    int exp_bs;
    exp_bs = (m_bk >= 1 && m_bk <= L && ((m_bk - 1) % T) < TRAS) ? 0 : 1;
    check("banksel_n", banksel_n, exp_bs);
    check("raddr", raddr, m_raddr);
    check("rf_busy", rf_busy, (m_bk >= 1) ? 1 : 0);
    check("rf_done", rf_done, (m_bk == L + 1) ? 1 : 0);
    check("rf_req", rf_req, m_req);
  endtask

  task automatic cyc(input logic st, input logic en);
    rf_start = st;
    rf_en = en;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic burst(input logic en);
    cyc(1'b1, en);
    repeat (L + 2) cyc(1'b0, en);
  endtask

  initial begin
    int i;
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; rf_en = 1'b0; rf_start = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;

    // first request after one full interval plus the register stage
    for (i = 1; i <= 40; i++) begin
      cyc(1'b0, 1'b1);
      if (rf_req) break;
    end
    check("req_rise_cycle", i, PERIOD + 1);

    // single granted burst
    cyc(1'b1, 1'b1);
    repeat (L + 3) cyc(1'b0, 1'b1);
    check("raddr_after_burst", raddr, 2);

    // saturate pending, then retire it with the interval timer disabled
    repeat (200) cyc(1'b0, 1'b1);
    for (int b = 0; b < 8; b++) begin
      burst(1'b0);
      check("req_after_burst", rf_req, (b < 6) ? 1 : 0);
    end

    // bring row pointer to 14 and refresh across the wrap
    repeat (6) burst(1'b0);
    check("ptr_before_wrap", raddr, 14);
    burst(1'b0);
    burst(1'b0);

    // grant pulses during ACT/PRE are ignored; rf_en drop mid-burst
    cyc(1'b1, 1'b1);
    repeat (3) cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    repeat (2) cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    repeat (3) cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    repeat (L) cyc(1'b0, 1'b0);

    // async reset during ACT
    repeat (25) cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    repeat (2) cyc(1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;

    for (int n = 0; n < 3000; n++)
      cyc(($urandom_range(0, 7) == 0), ($urandom_range(0, 9) != 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
